// File: rtl/sample_packer.sv
// ADC sample formatter: signed left-justified words (mode 0) or LSB-first bit packing (mode 1).
// Optional sticky clip detector enabled by defining SAMPLE_PACKER_CLIP_DETECT_EN.
module sample_packer #(
    parameter int SAMPLE_WIDTH = 10,
    parameter int OUT_WIDTH    = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               mode,
    input  logic [SAMPLE_WIDTH-1:0]            dataIn,
    input  logic                               dataInValid,
    input  logic                               flush,
    output logic [OUT_WIDTH-1:0]               dataOut,
    output logic                               dataOutValid,
    output logic                               dataOutLast,
    output logic [$clog2(OUT_WIDTH+1)-1:0]     pendingBits,
    output logic                               clipFlag
);

    localparam int ACC_W  = SAMPLE_WIDTH + OUT_WIDTH - 1;
    localparam int PEND_W = $clog2(OUT_WIDTH + 1);
    localparam int TOT_W  = $clog2(2 * OUT_WIDTH);

    // Offset-binary to two's complement is an MSB flip; then left-justify.
    function automatic logic [OUT_WIDTH-1:0] unpack_word(input logic [SAMPLE_WIDTH-1:0] d);
        logic [SAMPLE_WIDTH-1:0] s;
        s = d ^ (SAMPLE_WIDTH'(1) << (SAMPLE_WIDTH - 1));
        return OUT_WIDTH'(s) << (OUT_WIDTH - SAMPLE_WIDTH);
    endfunction

    logic [ACC_W-1:0]     acc_q, acc_d, acc_ins;
    logic [PEND_W-1:0]    pend_q, pend_d;
    logic [TOT_W-1:0]     total;
    logic                 active_mode_q, active_mode_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 flush_req;
    logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;

    always_comb begin
        acc_ins       = acc_q | (ACC_W'(dataIn) << pend_q);
        total         = TOT_W'(pend_q) + TOT_W'(SAMPLE_WIDTH);
        flush_req     = flush | flush_pend_q;
        acc_d         = acc_q;
        pend_d        = pend_q;
        flush_pend_d  = flush_pend_q;
        data_out_d    = data_out_q;
        valid_d       = 1'b0;
        last_d        = 1'b0;

        if (!active_mode_q) begin
            flush_pend_d = 1'b0;
            if (dataInValid) begin
                data_out_d = unpack_word(dataIn);
                valid_d    = 1'b1;
            end
        end else if (dataInValid) begin
            // A flush that collides with a sample waits for the first idle cycle.
            if (flush_req) begin
                flush_pend_d = 1'b1;
            end
            if (total >= TOT_W'(OUT_WIDTH)) begin
                data_out_d = acc_ins[OUT_WIDTH-1:0];
                valid_d    = 1'b1;
                acc_d      = acc_ins >> OUT_WIDTH;
                pend_d     = PEND_W'(total - TOT_W'(OUT_WIDTH));
            end else begin
                acc_d  = acc_ins;
                pend_d = PEND_W'(total);
            end
        end else if (flush_req) begin
            flush_pend_d = 1'b0;
            if (pend_q != '0) begin
                // Bits above pend_q are always zero, so this word is already padded.
                data_out_d = acc_q[OUT_WIDTH-1:0];
                valid_d    = 1'b1;
                last_d     = 1'b1;
                acc_d      = '0;
                pend_d     = '0;
            end
        end

        active_mode_d = (pend_d == '0) ? mode : active_mode_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q         <= '0;
            pend_q        <= '0;
            active_mode_q <= 1'b0;
            flush_pend_q  <= 1'b0;
            data_out_q    <= '0;
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            pend_q        <= pend_d;
            active_mode_q <= active_mode_d;
            flush_pend_q  <= flush_pend_d;
            data_out_q    <= data_out_d;
            valid_q       <= valid_d;
            last_q        <= last_d;
        end
    end

    assign dataOut      = data_out_q;
    assign dataOutValid = valid_q;
    assign dataOutLast  = last_q;
    assign pendingBits  = pend_q;

`ifdef SAMPLE_PACKER_CLIP_DETECT_EN
    logic clip_q, clip_d;

    always_comb begin
        clip_d = clip_q;
        if (dataInValid && ((dataIn == '0) || (dataIn == '1))) begin
            clip_d = 1'b1;
        end else if (flush && (pend_q == '0) && !flush_pend_q) begin
            clip_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clip_q <= 1'b0;
        end else begin
            clip_q <= clip_d;
        end
    end

    assign clipFlag = clip_q;
`else
    assign clipFlag = 1'b0;
`endif

endmodule

// File: tb/tb_sample_packer.sv
// Bench for sample_packer: directed vector table, reset sequences and a randomized
// run against a bit-queue reference model.
module tb_sample_packer;

    localparam int SW = 10;
    localparam int OW = 16;
    localparam int PW = 5;

`ifdef SAMPLE_PACKER_CLIP_DETECT_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          mode;
    logic [SW-1:0] dataIn;
    logic          dataInValid;
    logic          flush;
    logic [OW-1:0] dataOut;
    logic          dataOutValid;
    logic          dataOutLast;
    logic [PW-1:0] pendingBits;
    logic          clipFlag;

    sample_packer #(.SAMPLE_WIDTH(SW), .OUT_WIDTH(OW)) dut (
        .clock        (clock),
        .reset        (reset),
        .mode         (mode),
        .dataIn       (dataIn),
        .dataInValid  (dataInValid),
        .flush        (flush),
        .dataOut      (dataOut),
        .dataOutValid (dataOutValid),
        .dataOutLast  (dataOutLast),
        .pendingBits  (pendingBits),
        .clipFlag     (clipFlag)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic          m;
        logic [SW-1:0] din;
        logic          vld;
        logic          fl;
        logic [OW-1:0] eout;
        logic          evld;
        logic          elast;
        logic [PW-1:0] epend;
        logic          eclip;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic m, input logic [SW-1:0] din, input logic vld, input logic fl,
                       input logic [OW-1:0] eout, input logic evld, input logic elast,
                       input logic [PW-1:0] epend, input logic eclip);
        vec_t v;
        v.m = m; v.din = din; v.vld = vld; v.fl = fl;
        v.eout = eout; v.evld = evld; v.elast = elast; v.epend = epend; v.eclip = eclip;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [OW-1:0] eo, input logic ev, input logic el,
                         input logic [PW-1:0] ep, input logic ec, input bit force_out);
        bit bad;
        logic eclip;
        eclip = ec & CLIP_EN;
        n_vec++;
        bad = (dataOutValid !== ev) || (pendingBits !== ep) || (clipFlag !== eclip);
        if ((ev || force_out) && ((dataOut !== eo) || (dataOutLast !== el))) bad = 1'b1;
        if (bad) begin
            n_err++;
            $display("FAIL %s: got out=%h vld=%b last=%b pend=%0d clip=%b, want out=%h vld=%b last=%b pend=%0d clip=%b",
                     nm, dataOut, dataOutValid, dataOutLast, pendingBits, clipFlag, eo, ev, el, ep, eclip);
        end
    endtask

    task automatic drive(input logic m, input logic [SW-1:0] d, input logic v, input logic f);
        mode = m; dataIn = d; dataInValid = v; flush = f;
        @(posedge clock);
        #1;
    endtask

    // Reference model: packed residue is a plain FIFO of bits, LSB of each sample first.
    bit mq[$];
    bit m_act, m_fp, m_clip;

    task automatic model_reset();
        mq.delete();
        m_act = 1'b0; m_fp = 1'b0; m_clip = 1'b0;
    endtask

    task automatic model_step(input bit m, input logic [SW-1:0] d, input bit v, input bit f,
                              output logic [OW-1:0] eo, output bit ev, output bit el, output int ep);
        int  pend0;
        bit  fp0;
        pend0 = mq.size();
        fp0   = m_fp;
        eo = '0; ev = 1'b0; el = 1'b0;
        if (!m_act) begin
            m_fp = 1'b0;
            if (v) begin
                eo = 16'((int'(d) - 512) * 64);
                ev = 1'b1;
            end
        end else if (v) begin
            for (int i = 0; i < SW; i++) mq.push_back(d[i]);
            if (f || m_fp) m_fp = 1'b1;
            if (mq.size() >= OW) begin
                for (int i = 0; i < OW; i++) eo[i] = mq.pop_front();
                ev = 1'b1;
            end
        end else if (f || m_fp) begin
            m_fp = 1'b0;
            if (mq.size() > 0) begin
                for (int i = 0; mq.size() > 0; i++) eo[i] = mq.pop_front();
                ev = 1'b1;
                el = 1'b1;
            end
        end
        if (v && (d == 0 || d == 1023)) m_clip = 1'b1;
        else if (f && pend0 == 0 && !fp0) m_clip = 1'b0;
        if (mq.size() == 0) m_act = m;
        ep = mq.size();
    endtask

    initial begin
        logic [7:0]    pat8;
        int            pend_tab[8];
        logic [OW-1:0] eo;
        bit            ev, el;
        int            ep;
        bit            rm, rv, rf;
        logic [SW-1:0] rd;
        int            r;

        pat8     = 8'b11011010;
        pend_tab = '{10, 4, 14, 8, 2, 12, 6, 0};

        // Unpacked mode, then switch to packed while idle.
        add(0, 10'h200, 1, 0, 16'h0000, 1, 0, 0, 0);
        add(0, 10'h000, 1, 0, 16'h8000, 1, 0, 0, 1);
        add(0, 10'h3FF, 1, 0, 16'h7FC0, 1, 0, 0, 1);
        add(0, 10'h000, 0, 0, 16'h0000, 0, 0, 0, 1);
        add(1, 10'h000, 0, 0, 16'h0000, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++)
            add(1, 10'h3FF, 1, 0, 16'hFFFF, pat8[k], 0, PW'(pend_tab[k]), 1);
        // Packing with idle flush, then flush colliding with a sample.
        add(1, 10'h001, 1, 0, 16'h0000, 0, 0, 10, 1);
        add(1, 10'h002, 1, 0, 16'h0801, 1, 0, 4, 1);
        add(1, 10'h000, 0, 1, 16'h0000, 1, 1, 0, 1);
        add(1, 10'h001, 1, 0, 16'h0000, 0, 0, 10, 1);
        add(1, 10'h002, 1, 0, 16'h0801, 1, 0, 4, 1);
        add(1, 10'h3FF, 1, 1, 16'h0000, 0, 0, 14, 1);
        add(1, 10'h000, 0, 0, 16'h3FF0, 1, 1, 0, 1);
        // Pending flush held across a following sample.
        add(1, 10'h3FF, 1, 1, 16'h0000, 0, 0, 10, 1);
        add(1, 10'h001, 1, 0, 16'h07FF, 1, 0, 4, 1);
        add(1, 10'h000, 0, 0, 16'h0000, 1, 1, 0, 1);
        add(1, 10'h000, 0, 1, 16'h0000, 0, 0, 0, 0);
        // Mode 1->0 mid-word: packing continues until the residue drains.
        add(1, 10'h3FF, 1, 0, 16'h0000, 0, 0, 10, 1);
        add(0, 10'h3FF, 1, 0, 16'hFFFF, 1, 0, 4, 1);
        add(0, 10'h3FF, 1, 0, 16'h0000, 0, 0, 14, 1);
        add(0, 10'h3FF, 1, 0, 16'hFFFF, 1, 0, 8, 1);
        add(0, 10'h3FF, 1, 0, 16'hFFFF, 1, 0, 2, 1);
        add(0, 10'h3FF, 1, 0, 16'h0000, 0, 0, 12, 1);
        add(0, 10'h3FF, 1, 0, 16'hFFFF, 1, 0, 6, 1);
        add(0, 10'h3FF, 1, 0, 16'hFFFF, 1, 0, 0, 1);
        add(0, 10'h3FF, 1, 0, 16'h7FC0, 1, 0, 0, 1);
        add(0, 10'h000, 0, 1, 16'h0000, 0, 0, 0, 0);

        reset = 1'b1; mode = 1'b0; dataIn = '0; dataInValid = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", 16'h0000, 0, 0, 0, 0, 1);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].m, tbl[i].din, tbl[i].vld, tbl[i].fl);
            check($sformatf("row%0d", i), tbl[i].eout, tbl[i].evld, tbl[i].elast, tbl[i].epend, tbl[i].eclip, 0);
        end

        // Reset mid-word: residue is discarded, nothing is emitted afterwards.
        drive(1, 10'h000, 0, 0);
        check("pre_reset_idle", 16'h0000, 0, 0, 0, 0, 0);
        drive(1, 10'h3FF, 1, 0);
        check("pre_reset_sample", 16'h0000, 0, 0, 10, 1, 0);
        reset = 1'b1;
        #1;
        check("reset_mid_word", 16'h0000, 0, 0, 0, 0, 1);
        #3;
        reset = 1'b0;
        drive(1, 10'h000, 0, 1);
        check("post_reset_flush", 16'h0000, 0, 0, 0, 0, 0);

        // Randomized run against the reference model.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        rm = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) rm = ~rm;
            rv = ($urandom_range(0, 9) < 7);
            rf = ($urandom_range(0, 9) == 0);
            r  = $urandom_range(0, 15);
            rd = (r == 0) ? 10'h000 : (r == 1) ? 10'h3FF : SW'($urandom);
            model_step(rm, rd, rv, rf, eo, ev, el, ep);
            drive(rm, rd, rv, rf);
            check($sformatf("rand%0d", c), eo, ev, el, PW'(ep), m_clip, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sample_packer.md
Name: sample_packer

Overview:
- Parametrised successor to the fixed 10-to-16-bit converter. Sits in the ADC clock domain between the data generator and the FIFO buffer.
- Supports two output formats:
  - Mode 0 (unpacked): each sample becomes one signed, left-justified OUT_WIDTH word.
  - Mode 1 (packed): raw unsigned samples are bit-packed LSB-first into OUT_WIDTH words, giving more samples per USB word.
- A flush pulse emits any residual packed bits as a zero-padded final word.

Parameters:
- SAMPLE_WIDTH, 10, ADC sample width in bits; legal range 1..OUT_WIDTH.
- OUT_WIDTH, 16, output word width in bits (FX3 databus width).

Ports:
- clock  input  1  ADC sample clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mode  input  1  0 = unpacked signed, 1 = packed raw.
- dataIn  input  SAMPLE_WIDTH  unsigned offset-binary sample.
- dataInValid  input  1  dataIn is valid this cycle.
- flush  input  1  single-cycle request to emit the residual packed word.
- dataOut  output  OUT_WIDTH  output word.
- dataOutValid  output  1  dataOut is valid; one-cycle pulse per word.
- dataOutLast  output  1  marks a zero-padded flush word; qualified by dataOutValid.
- pendingBits  output  $clog2(OUT_WIDTH+1)  residual bits held in the accumulator.
- clipFlag  output  1  sticky ADC-clip indicator (CLIP_DETECT_EN only; tied 0 otherwise).

Behaviour:
- Reset (async) values:
  - dataOut=0, dataOutValid=0, dataOutLast=0, pendingBits=0, clipFlag=0.
  - accumulator=0, activeMode=0, flushPending=0.
- activeMode:
  - Loads from mode on any clock edge where post-update pendingBits==0.
  - A mode change mid-word takes effect only after the current word completes or is flushed.
- No backpressure. One sample is accepted per cycle whenever dataInValid=1.
- Mode 0 (unpacked):
  - dataOut = {~dataIn[MSB], dataIn[MSB-1:0]} << (OUT_WIDTH-SAMPLE_WIDTH), registered.
  - dataOutValid asserts on the edge after dataInValid, so latency is 1 cycle.
  - pendingBits stays 0. flush has no effect, and dataOutLast is never set.
- Mode 1 (packed):
  - Each accepted sample is appended at bit position pendingBits of an accumulator of width SAMPLE_WIDTH+OUT_WIDTH-1.
  - When the total reaches OUT_WIDTH or more, the low OUT_WIDTH bits are registered to dataOut with dataOutValid=1, the accumulator shifts right by OUT_WIDTH, and pendingBits = total-OUT_WIDTH.
  - At most one word is produced per sample.
  - Latency: the word appears on the edge after the completing sample.
  - For 10/16: 8 samples produce 5 words, and pendingBits cycles 10,4,14,8,2,12,6,0.
- flush (packed):
  - If pendingBits>0 and dataInValid=0: next edge emits the residual bits with upper bits zeroed, dataOutValid=1, dataOutLast=1, then pendingBits=0.
  - If pendingBits==0: no output.
  - If flush and dataInValid coincide: the sample is processed normally, flushPending is set, and the flush executes on the next edge.
  - If a new sample also arrives on that next edge, the sample is deferred... no sample is dropped. Instead, the flush is held pending until the first cycle with dataInValid=0.
- flush arriving while flushPending=1 is merged (idempotent).
- Mid-operation reset discards the residual bits with no output word.

Optional Feature:
- Macro: SAMPLE_PACKER_CLIP_DETECT_EN.
- Defined:
  - clipFlag sets on the edge after an accepted sample equal to 0 or 2^SAMPLE_WIDTH-1.
  - clipFlag is sticky until reset, or until a flush with pendingBits==0 (no pending flush).
  - Flag logic adds no latency to the data path.
- Undefined: clipFlag is constant 0 and no clip logic is synthesised.

Test Plan:
- Mode 0, SAMPLE_WIDTH=10:
  - dataIn 0x200, 0x000, 0x3FF on consecutive cycles -> dataOut 0x0000, 0x8000, 0x7FC0.
  - Each appears 1 cycle after its input with dataOutValid pulses. pendingBits=0 throughout.
- Mode 1:
  - 8 consecutive samples 0x3FF -> exactly 5 words of 0xFFFF on edges after samples 2,4,5,7,8.
  - pendingBits ends at 0; dataOutLast=0 on all words.
- Mode 1:
  - samples 0x001, 0x002 -> word 0x0801 after the 2nd sample, pendingBits=4.
  - flush -> next cycle word 0x0000 with dataOutLast=1, pendingBits=0.
- Mode 1: flush coincident with a third sample 0x3FF after pendingBits=4:
  - Sample accepted, pendingBits=14, no word that edge.
  - Next idle cycle emits 0x3FF0 with dataOutLast=1.
- Mode switch and reset:
  - Switch mode 1->0 with pendingBits=4 -> samples keep packing until a word completes (pendingBits 14, then 8...). Unpacked output begins only after pendingBits reaches 0 (or a flush).
  - Separately, assert reset mid-word -> all outputs 0 immediately, no word emitted.
- With SAMPLE_PACKER_CLIP_DETECT_EN:
  - sample 0x3FF -> clipFlag=1 on the next edge.
  - Flush with pendingBits==0 -> clipFlag=0.
  - Without the macro, clipFlag stays 0 for the same stimulus.
